// File: rtl/ldmx_daq_pkg.sv
// Event tag layout shared by the tag queue and the DAQ buffer block.
// Field offsets and widths here are the contract both sides slice evttag with.
package ldmx_daq_pkg;

    localparam int BXID_W    = 12;
    localparam int SPILL_W   = 12;
    localparam int TIS_W     = 32;
    localparam int EVTID_W   = 32;
    localparam int TAG_W     = BXID_W + SPILL_W + TIS_W + EVTID_W;

    localparam int BXID_LSB  = 0;
    localparam int SPILL_LSB = BXID_LSB + BXID_W;
    localparam int TIS_LSB   = SPILL_LSB + SPILL_W;
    localparam int EVTID_LSB = TIS_LSB + TIS_W;

    typedef struct packed {
        logic [EVTID_W-1:0] evtid;
        logic [TIS_W-1:0]   tis;
        logic [SPILL_W-1:0] spill;
        logic [BXID_W-1:0]  bxid;
    } tag_t;

    function automatic tag_t tag_pack(
        input logic [EVTID_W-1:0] evtid,
        input logic [TIS_W-1:0]   tis,
        input logic [SPILL_W-1:0] spill,
        input logic [BXID_W-1:0]  bxid
    );
        tag_t t;
        t.evtid = evtid;
        t.tis   = tis;
        t.spill = spill;
        t.bxid  = bxid;
        return t;
    endfunction

endpackage

// File: rtl/evttag_fifo.sv
// Synchronous FIFO with a registered head word (zero when empty) and occupancy count.
// Latency: push at cycle N is visible at the head in N+1; head refreshes the cycle after a pop.
// Backpressure: push refused when full unless a pop frees the slot in the same cycle; pop when empty ignored.
module evttag_fifo #(
    parameter int WIDTH      = 88,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      push_dat,
    output logic [WIDTH-1:0]      head_dat,
    output logic [DEPTH_LOG2:0]   occupancy,
    output logic [DEPTH_LOG2:0]   occ_nxt,
    output logic                  full,
    output logic                  push_acc
);

    localparam int                DEPTH     = 2**DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] rd_nxt;
    logic [WIDTH-1:0]      head_nxt;
    logic                  pop_ok;

    assign full     = (occupancy == DEPTH_CNT);
    assign pop_ok   = pop && !clear && (occupancy != '0);
    assign push_acc = push && !clear && (!full || pop_ok);
    assign rd_nxt   = pop_ok ? rd_ptr + 1'b1 : rd_ptr;

    // The new head comes straight from push_dat when it lands in the slot rd_nxt points at.
    always_comb begin
        occ_nxt = occupancy;
        if (clear) begin
            occ_nxt = '0;
        end else if (push_acc && !pop_ok) begin
            occ_nxt = occupancy + 1'b1;
        end else if (!push_acc && pop_ok) begin
            occ_nxt = occupancy - 1'b1;
        end
        head_nxt = '0;
        if (occ_nxt != '0) begin
            head_nxt = (push_acc && (rd_nxt == wr_ptr)) ? push_dat : mem[rd_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            head_dat  <= '0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            head_dat  <= '0;
        end else begin
            if (push_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr    <= rd_nxt;
            occupancy <= occ_nxt;
            head_dat  <= head_nxt;
        end
    end

endmodule

// File: rtl/ldmx_evttag_queue.sv
// Timestamps each L1A with {evtid, time_in_spill, spill, bxid} and queues tags for the DAQ; EVTTAG_BUSY_EN adds busy hysteresis.
// Latency: l1a at cycle N -> tag at head, tag_valid=1, in N+1; head refreshes the cycle after tagdone.
// Backpressure: l1a while full (no same-cycle tagdone) is dropped and counted; busy requests trigger throttling.
module ldmx_evttag_queue
    import ldmx_daq_pkg::*;
#(
    parameter int DEPTH_LOG2  = 4,
    parameter int BXID_MAX    = 3563
`ifdef EVTTAG_BUSY_EN
    ,
    parameter int BUSY_THRESH = 12
`endif
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  bc0,
    input  logic                  spill_start,
    input  logic                  l1a,
    input  logic                  tagdone,
    output logic [TAG_W-1:0]      evttag,
    output logic                  tag_valid,
    output logic [DEPTH_LOG2:0]   occupancy,
    output logic                  full,
    output logic                  busy,
    output logic [15:0]           drop_count
);

    logic [BXID_W-1:0]    bxid;
    logic [SPILL_W-1:0]   spill;
    logic [TIS_W-1:0]     tis;
    logic [EVTID_W-1:0]   evtid;
    logic [DEPTH_LOG2:0]  occ_nxt;
    logic                 push_acc;
    logic                 drop;
    tag_t                 cap_tag;

    // Capture uses this cycle's counter values, before any same-cycle update.
    assign cap_tag   = tag_pack(evtid, tis, spill, bxid);
    assign drop      = l1a && !clear && !push_acc;
    assign tag_valid = (occupancy != '0);

    evttag_fifo #(
        .WIDTH      (TAG_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (clear),
        .push       (l1a),
        .pop        (tagdone),
        .push_dat   (cap_tag),
        .head_dat   (evttag),
        .occupancy  (occupancy),
        .occ_nxt    (occ_nxt),
        .full       (full),
        .push_acc   (push_acc)
    );

    // Timebase keeps running through clear; only reset stops it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bxid  <= '0;
            spill <= '0;
            tis   <= '0;
        end else begin
            if (bc0 || (bxid == BXID_W'(BXID_MAX))) begin
                bxid <= '0;
            end else begin
                bxid <= bxid + 1'b1;
            end
            if (spill_start) begin
                spill <= spill + 1'b1;
                tis   <= '0;
            end else if (tis != '1) begin
                tis <= tis + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            evtid      <= '0;
            drop_count <= '0;
        end else if (clear) begin
            evtid      <= '0;
            drop_count <= '0;
        end else begin
            if (l1a) begin
                evtid <= evtid + 1'b1;
            end
            if (drop && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

`ifdef EVTTAG_BUSY_EN
    localparam logic [DEPTH_LOG2:0] BUSY_ON  = (DEPTH_LOG2+1)'(BUSY_THRESH);
    localparam logic [DEPTH_LOG2:0] BUSY_OFF = (DEPTH_LOG2+1)'(BUSY_THRESH / 2);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy <= 1'b0;
        end else if (occ_nxt >= BUSY_ON) begin
            busy <= 1'b1;
        end else if (occ_nxt <= BUSY_OFF) begin
            busy <= 1'b0;
        end
    end
`else
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(2**DEPTH_LOG2);

    // Registered from next occupancy so busy lines up with full.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy <= 1'b0;
        end else begin
            busy <= (occ_nxt == FULL_CNT);
        end
    end
`endif

endmodule

// File: tb/tb_ldmx_evttag_queue.sv
// Scoreboard bench for ldmx_evttag_queue: stimulus queues expected tags, a negedge monitor checks each popped head.
module tb_ldmx_evttag_queue;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clear;
    logic        bc0;
    logic        spill_start;
    logic        l1a;
    logic        tagdone;
    logic [87:0] evttag;
    logic        tag_valid;
    logic [4:0]  occupancy;
    logic        full;
    logic        busy;
    logic [15:0] drop_count;

    logic [87:0] exp_q [$];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    ldmx_evttag_queue dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (clear),
        .bc0         (bc0),
        .spill_start (spill_start),
        .l1a         (l1a),
        .tagdone     (tagdone),
        .evttag      (evttag),
        .tag_valid   (tag_valid),
        .occupancy   (occupancy),
        .full        (full),
        .busy        (busy),
        .drop_count  (drop_count)
    );

    function automatic logic [87:0] tag(input logic [31:0] e, input logic [31:0] t,
                                        input logic [11:0] s, input logic [11:0] b);
        return {e, t, s, b};
    endfunction

    task automatic check(input string name, input logic [87:0] act, input logic [87:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a head consumed by tagdone must match the oldest expected tag.
    always @(negedge clk) begin
        if (reset_n && !clear && tagdone && tag_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_tag: got %0h expected no tag (scoreboard empty)", evttag);
            end else begin
                check("pop_tag", evttag, exp_q.pop_front());
            end
        end
    end

    task automatic pulse(input logic a_l1a, input logic a_done, input logic a_bc0,
                         input logic a_sp, input logic a_clr);
        l1a         = a_l1a;
        tagdone     = a_done;
        bc0         = a_bc0;
        spill_start = a_sp;
        clear       = a_clr;
        @(posedge clk);
        #1;
        l1a         = 1'b0;
        tagdone     = 1'b0;
        bc0         = 1'b0;
        spill_start = 1'b0;
        clear       = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n     = 1'b0;
        clear       = 1'b0;
        bc0         = 1'b0;
        spill_start = 1'b0;
        l1a         = 1'b0;
        tagdone     = 1'b0;
        idle(3);
        check("rst_tag_valid", tag_valid, 0);
        check("rst_evttag", evttag, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_full", full, 0);
        check("rst_busy", busy, 0);
        check("rst_drop", drop_count, 0);
        reset_n = 1'b1;

        // First cycle after reset: all counters 0; spill_start/bc0 only affect later tags.
        pulse(1, 0, 1, 1, 0);
        exp_q.push_back(tag(0, 0, 0, 0));
        check("head_first", evttag, tag(0, 0, 0, 0));
        check("valid_first", tag_valid, 1);
        idle(4);
        pulse(1, 0, 0, 0, 0);
        exp_q.push_back(tag(1, 4, 1, 4));
        check("occ_two", occupancy, 2);
        pulse(0, 1, 0, 0, 0);
        pulse(0, 1, 0, 0, 0);
        check("occ_drained1", occupancy, 0);

        // bxid wrap at 3563 and bc0 at bxid 100.
        pulse(0, 0, 1, 1, 0);
        idle(3563);
        pulse(1, 0, 0, 0, 0);
        exp_q.push_back(tag(2, 3563, 2, 3563));
        pulse(1, 0, 0, 0, 0);
        exp_q.push_back(tag(3, 3564, 2, 0));
        pulse(0, 0, 1, 1, 0);
        idle(100);
        pulse(1, 0, 1, 0, 0);
        exp_q.push_back(tag(4, 100, 3, 100));
        pulse(1, 0, 0, 0, 0);
        exp_q.push_back(tag(5, 101, 3, 0));
        check("occ_four", occupancy, 4);
        repeat (4) pulse(0, 1, 0, 0, 0);
        check("occ_drained2", occupancy, 0);
        check("evttag_empty", evttag, 0);

        // clear overrides same-cycle l1a/tagdone and zeroes evtid.
        pulse(1, 0, 0, 0, 0);
        pulse(1, 0, 0, 0, 0);
        check("occ_pre_clear", occupancy, 2);
        pulse(1, 1, 0, 0, 1);
        check("clear_occ", occupancy, 0);
        check("clear_valid", tag_valid, 0);
        check("clear_evttag", evttag, 0);
        check("clear_drop", drop_count, 0);

        // Fill with 17 l1a: 16 stored, one dropped.
        pulse(0, 0, 1, 1, 0);
        for (int i = 0; i < 17; i++) begin
            pulse(1, 0, 0, 0, 0);
            if (i < 16) exp_q.push_back(tag(i, i, 4, i));
            check("fill_occ", occupancy, (i < 16) ? i + 1 : 16);
`ifdef EVTTAG_BUSY_EN
            check("fill_busy", busy, (i + 1) >= 12);
`else
            check("fill_busy", busy, (i + 1) >= 16);
`endif
        end
        check("fill_full", full, 1);
        check("fill_drop", drop_count, 1);

        // Full with l1a+tagdone: pop wins the slot, push accepted with evtid 17.
        pulse(1, 1, 0, 0, 0);
        exp_q.push_back(tag(17, 17, 4, 17));
        check("both_full_occ", occupancy, 16);
        check("both_full_drop", drop_count, 1);
        check("both_full_full", full, 1);

        for (int k = 0; k < 16; k++) begin
            pulse(0, 1, 0, 0, 0);
            check("drain_occ", occupancy, 15 - k);
`ifdef EVTTAG_BUSY_EN
            check("drain_busy", busy, (15 - k) > 6);
`else
            check("drain_busy", busy, 0);
`endif
        end
        check("drain_full", full, 0);
        check("drain_valid", tag_valid, 0);

        // tagdone while empty is ignored.
        pulse(0, 1, 0, 0, 0);
        check("empty_pop_occ", occupancy, 0);
        check("empty_pop_tag", evttag, 0);
        check("empty_pop_drop", drop_count, 1);

        // l1a+tagdone when empty pushes only; when non-empty swaps the entry.
        pulse(0, 0, 1, 1, 0);
        pulse(1, 1, 0, 0, 0);
        exp_q.push_back(tag(18, 0, 5, 0));
        check("both_empty_occ", occupancy, 1);
        check("both_empty_head", evttag, tag(18, 0, 5, 0));
        pulse(1, 1, 0, 0, 0);
        exp_q.push_back(tag(19, 1, 5, 1));
        check("both_one_occ", occupancy, 1);
        check("both_one_head", evttag, tag(19, 1, 5, 1));
        pulse(0, 1, 0, 0, 0);
        check("occ_drained3", occupancy, 0);

        // Asynchronous reset mid-run with 5 tags queued.
        repeat (5) pulse(1, 0, 0, 0, 0);
        check("pre_rst_occ", occupancy, 5);
        reset_n = 1'b0;
        #1;
        check("arst_valid", tag_valid, 0);
        check("arst_evttag", evttag, 0);
        check("arst_occ", occupancy, 0);
        check("arst_drop", drop_count, 0);
        check("arst_busy", busy, 0);
        idle(2);
        reset_n = 1'b1;
        pulse(1, 0, 0, 0, 0);
        exp_q.push_back(tag(0, 0, 0, 0));
        check("post_rst_head", evttag, tag(0, 0, 0, 0));
        pulse(0, 1, 0, 0, 0);
        check("post_rst_occ", occupancy, 0);

        idle(2);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
